// File: rtl/gc_updt_tx.sv
// Publishes a 64-bit GC value to a host address as a single 3-beat
// 64-bit-address MWr TLP on a shared TRN TX port.
module gc_updt_tx (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] gc_addr,
  input  logic        gc_updt,
  output logic        gc_updt_ack,
  input  logic [63:0] gc_host_addr,
  input  logic        gc_host_addr_vld,
  input  logic [15:0] cfg_completer_id,
  output logic        tx_req,
  input  logic        tx_gnt,
  output logic        tx_busy,
  output logic [63:0] trn_td,
  output logic [7:0]  trn_trem_n,
  output logic        trn_tsof_n,
  output logic        trn_teof_n,
  output logic        trn_tsrc_rdy_n,
  input  logic        trn_tdst_rdy_n,
  input  logic [3:0]  trn_tbuf_av,
  output logic [31:0] drop_cnt
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ARB   = 3'd1;
  localparam logic [2:0] BEAT0 = 3'd2;
  localparam logic [2:0] BEAT1 = 3'd3;
  localparam logic [2:0] BEAT2 = 3'd4;

  logic [2:0]  state_reg;
  logic [63:0] gc_reg;
  logic [63:0] host_reg;
  logic        accept;
  logic        launch;
  logic        unused_tbuf;

  // Host is little-endian: each DW goes out byte-reversed.
  function automatic logic [31:0] bswap32(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  // The ack cycle itself is not an acceptance window, so a request still
  // held high during its own ack is not taken twice.
  assign accept = (state_reg == IDLE) && gc_updt && !gc_updt_ack;
  assign launch = (state_reg == ARB) && tx_gnt && trn_tbuf_av[1] && !trn_tdst_rdy_n;
  assign unused_tbuf = ^{trn_tbuf_av[3:2], trn_tbuf_av[0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      gc_reg         <= 64'd0;
      host_reg       <= 64'd0;
      gc_updt_ack    <= 1'b0;
      tx_req         <= 1'b0;
      tx_busy        <= 1'b0;
      trn_td         <= 64'd0;
      trn_trem_n     <= 8'hFF;
      trn_tsof_n     <= 1'b1;
      trn_teof_n     <= 1'b1;
      trn_tsrc_rdy_n <= 1'b1;
      drop_cnt       <= 32'd0;
    end else begin
      gc_updt_ack <= accept;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            gc_reg <= gc_addr;
            if (gc_host_addr_vld) begin
              host_reg  <= gc_host_addr;
              tx_req    <= 1'b1;
              state_reg <= ARB;
            end else begin
              drop_cnt <= drop_cnt + 32'd1;
            end
          end
        end
        ARB: begin
          if (launch) begin
            state_reg      <= BEAT0;
            tx_busy        <= 1'b1;
            trn_td         <= {32'h6000_0002, cfg_completer_id, 8'h00, 8'hFF};
            trn_tsof_n     <= 1'b0;
            trn_tsrc_rdy_n <= 1'b0;
            trn_trem_n     <= 8'h00;
          end
        end
        BEAT0: begin
          if (!trn_tdst_rdy_n) begin
            state_reg  <= BEAT1;
            trn_td     <= {host_reg[63:32], host_reg[31:2], 2'b00};
            trn_tsof_n <= 1'b1;
          end
        end
        BEAT1: begin
          if (!trn_tdst_rdy_n) begin
            state_reg  <= BEAT2;
            trn_td     <= {bswap32(gc_reg[31:0]), bswap32(gc_reg[63:32])};
            trn_teof_n <= 1'b0;
          end
        end
        BEAT2: begin
          if (!trn_tdst_rdy_n) begin
            state_reg      <= IDLE;
            tx_req         <= 1'b0;
            tx_busy        <= 1'b0;
            trn_td         <= 64'd0;
            trn_teof_n     <= 1'b1;
            trn_tsrc_rdy_n <= 1'b1;
            trn_trem_n     <= 8'hFF;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gc_updt_tx.sv
// Self-checking bench for gc_updt_tx: table vectors, directed corner
// sequences and a randomized run against a packet-level reference model.
module tb_gc_updt_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] gc_addr;
  logic        gc_updt;
  logic        gc_updt_ack;
  logic [63:0] gc_host_addr;
  logic        gc_host_addr_vld;
  logic [15:0] cfg_completer_id;
  logic        tx_req;
  logic        tx_gnt;
  logic        tx_busy;
  logic [63:0] trn_td;
  logic [7:0]  trn_trem_n;
  logic        trn_tsof_n;
  logic        trn_teof_n;
  logic        trn_tsrc_rdy_n;
  logic        trn_tdst_rdy_n;
  logic [3:0]  trn_tbuf_av;
  logic [31:0] drop_cnt;

  gc_updt_tx dut (
    .clk(clk), .rst(rst), .gc_addr(gc_addr), .gc_updt(gc_updt), .gc_updt_ack(gc_updt_ack),
    .gc_host_addr(gc_host_addr), .gc_host_addr_vld(gc_host_addr_vld),
    .cfg_completer_id(cfg_completer_id), .tx_req(tx_req), .tx_gnt(tx_gnt), .tx_busy(tx_busy),
    .trn_td(trn_td), .trn_trem_n(trn_trem_n), .trn_tsof_n(trn_tsof_n), .trn_teof_n(trn_teof_n),
    .trn_tsrc_rdy_n(trn_tsrc_rdy_n), .trn_tdst_rdy_n(trn_tdst_rdy_n),
    .trn_tbuf_av(trn_tbuf_av), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  function automatic void chk(input bit ok, input string nm,
                              input logic [63:0] act, input logic [63:0] req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", nm, act, req);
    end
  endfunction

  function automatic logic [31:0] swap_bytes(input logic [31:0] d);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(3-i) +: 8];
    return r;
  endfunction

  // ---------------- reference model / monitor ----------------
  logic [63:0] exp_q[$];
  logic [63:0] snap_gc, snap_host;
  logic        snap_vld;
  bit          model_on = 1'b0;
  bit          busy_m = 1'b0;
  bit          have_tlp_ack = 1'b0;
  bit          prev_hold = 1'b0;
  logic [63:0] prev_td;
  int          bidx = 0;
  int          cyc = 0;
  int          last_ack = 0;
  int          n_ack = 0;
  int          n_valid = 0;
  int          n_beats = 0;
  int          n_pkts = 0;
  int          model_drop = 0;

  // Inputs seen by the DUT on each active edge, for the acceptance decision.
  always @(posedge clk) begin
    snap_gc   <= gc_addr;
    snap_host <= gc_host_addr;
    snap_vld  <= gc_host_addr_vld;
  end

  always @(negedge clk) begin
    logic [63:0] e;
    cyc++;
    if (rst) begin
      exp_q.delete();
      busy_m = 0; bidx = 0; prev_hold = 0; model_drop = 0; have_tlp_ack = 0;
    end else begin
      if (gc_updt_ack) begin
        n_ack++;
        if (snap_vld) begin
          chk(!busy_m, "ack_overlap", 64'(busy_m), 64'd0);
          if (have_tlp_ack) chk((cyc - last_ack) >= 5, "ack_spacing", 64'(cyc - last_ack), 64'd5);
          have_tlp_ack = 1; last_ack = cyc; busy_m = 1;
          if (model_on) begin
            exp_q.push_back({32'h6000_0002, cfg_completer_id, 16'h00FF});
            exp_q.push_back(snap_host & ~64'd3);
            exp_q.push_back({swap_bytes(snap_gc[31:0]), swap_bytes(snap_gc[63:32])});
          end
        end else begin
          model_drop++;
        end
      end
      if (prev_hold) chk(!trn_tsrc_rdy_n && trn_td == prev_td, "beat_hold", trn_td, prev_td);
      prev_hold = 0;
      if (!trn_tsrc_rdy_n) begin
        n_valid++;
        if (!trn_tdst_rdy_n) begin
          if (exp_q.size() == 0) begin
            chk(0, "unexpected_beat", trn_td, 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk(trn_td == e, "beat_data", trn_td, e);
            chk({trn_tsof_n, trn_teof_n, tx_busy, tx_req} ==
                {bidx != 0, bidx != 2, 1'b1, 1'b1},
                "beat_frame", 64'({trn_tsof_n, trn_teof_n, tx_busy, tx_req}),
                64'({bidx != 0, bidx != 2, 1'b1, 1'b1}));
            if (bidx == 2) chk(trn_trem_n == 8'h00, "eof_trem", 64'(trn_trem_n), 64'h0);
          end
          bidx++; n_beats++;
          if (bidx == 3) begin
            bidx = 0; busy_m = 0; n_pkts++;
            $display("pkt %0d done at cycle %0d, last beat %h", n_pkts, cyc, trn_td);
          end
        end else begin
          prev_hold = 1; prev_td = trn_td;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic req_wait();
    bit ok;
    ok = 0;
    gc_updt = 1'b1;
    for (int c = 0; c < 50 && !ok; c++) begin
      tick();
      if (gc_updt_ack) ok = 1;
    end
    gc_updt = 1'b0;
    chk(ok, "ack_timeout", 64'(ok), 64'd1);
  endtask

  typedef struct {
    logic [63:0] gc;
    logic [63:0] host;
    logic [15:0] id;
    bit          stall;
    logic [63:0] b0, b1, b2;
    int          nvalid;
  } vec_t;

  vec_t vt[4];

  initial begin
    int a0, v0, k0, wcnt;
    bit stalled, found;

    vt[0] = '{64'h0000_0001_0000_0040, 64'h0000_0000_1234_5670, 16'h0100, 1'b0,
              64'h6000_0002_0100_00FF, 64'h0000_0000_1234_5670, 64'h4000_0000_0100_0000, 3};
    vt[1] = '{64'h1122_3344_5566_7788, 64'hFEDC_BA98_7654_3213, 16'hABCD, 1'b0,
              64'h6000_0002_ABCD_00FF, 64'hFEDC_BA98_7654_3210, 64'h8877_6655_4433_2211, 3};
    vt[2] = '{64'hDEAD_BEEF_0BAD_F00D, 64'h0000_0001_8000_0002, 16'h0000, 1'b0,
              64'h6000_0002_0000_00FF, 64'h0000_0001_8000_0000, 64'h0DF0_AD0B_EFBE_ADDE, 3};
    vt[3] = '{64'h0000_0001_0000_0040, 64'h0000_0000_1234_5670, 16'h0100, 1'b1,
              64'h6000_0002_0100_00FF, 64'h0000_0000_1234_5670, 64'h4000_0000_0100_0000, 6};

    rst = 1'b1; gc_addr = '0; gc_updt = 1'b0; gc_host_addr = '0; gc_host_addr_vld = 1'b0;
    cfg_completer_id = 16'h0100; tx_gnt = 1'b0; trn_tdst_rdy_n = 1'b1; trn_tbuf_av = 4'h0;

    // reset values, checked before the first clock edge
    #2;
    chk({gc_updt_ack, tx_req, tx_busy} == 3'b000, "rst_ctrl", 64'({gc_updt_ack, tx_req, tx_busy}), 64'd0);
    chk({trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n} == 3'b111, "rst_frame",
        64'({trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n}), 64'h7);
    chk(trn_trem_n == 8'hFF, "rst_trem", 64'(trn_trem_n), 64'hFF);
    chk(trn_td == 64'd0, "rst_td", trn_td, 64'd0);
    chk(drop_cnt == 32'd0, "rst_drop", 64'(drop_cnt), 64'd0);
    tick();
    rst = 1'b0;

    // table vectors: grant and core ready held
    model_on = 0;
    tx_gnt = 1'b1; trn_tdst_rdy_n = 1'b0; trn_tbuf_av = 4'hF; gc_host_addr_vld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      gc_addr = vt[i].gc; gc_host_addr = vt[i].host; cfg_completer_id = vt[i].id;
      exp_q.push_back(vt[i].b0); exp_q.push_back(vt[i].b1); exp_q.push_back(vt[i].b2);
      a0 = n_ack; v0 = n_valid; k0 = n_beats; stalled = 0;
      gc_updt = 1'b1;
      for (int c = 0; c < 16; c++) begin
        tick();
        if (gc_updt_ack) gc_updt = 1'b0;
        if (vt[i].stall && !stalled && !trn_tsrc_rdy_n && trn_tsof_n && trn_teof_n) begin
          stalled = 1;
          trn_tdst_rdy_n = 1'b1;
          repeat (3) tick();
          trn_tdst_rdy_n = 1'b0;
        end
      end
      gc_updt = 1'b0;
      chk(n_ack - a0 == 1, "vec_acks", 64'(n_ack - a0), 64'd1);
      chk(n_valid - v0 == vt[i].nvalid, "vec_valid_cycles", 64'(n_valid - v0), 64'(vt[i].nvalid));
      chk(n_beats - k0 == 3, "vec_beats", 64'(n_beats - k0), 64'd3);
      chk(exp_q.size() == 0, "vec_queue_empty", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end

    // host address not programmed: three dropped updates
    model_on = 1;
    cfg_completer_id = 16'h0100;
    do_reset();
    gc_host_addr_vld = 1'b0;
    a0 = n_ack; v0 = n_valid;
    for (int i = 0; i < 3; i++) begin
      gc_addr = {$urandom, $urandom};
      req_wait();
      tick();
    end
    repeat (4) tick();
    chk(n_ack - a0 == 3, "drop_acks", 64'(n_ack - a0), 64'd3);
    chk(drop_cnt == 32'd3, "drop_cnt", 64'(drop_cnt), 64'd3);
    chk(n_valid == v0, "drop_no_tlp", 64'(n_valid - v0), 64'd0);

    // posted buffers unavailable while in ARB
    gc_host_addr_vld = 1'b1; gc_addr = 64'h0000_0001_0000_0040; gc_host_addr = 64'h0000_0000_1234_5670;
    trn_tbuf_av = 4'b0000;
    req_wait();
    for (int i = 0; i < 10; i++) begin
      tick();
      chk(tx_req && trn_tsof_n && trn_tsrc_rdy_n, "arb_wait",
          64'({tx_req, trn_tsof_n, trn_tsrc_rdy_n}), 64'h7);
    end
    trn_tbuf_av = 4'b0010;
    tick();
    chk(!trn_tsof_n && !trn_tsrc_rdy_n, "arb_start", 64'({trn_tsof_n, trn_tsrc_rdy_n}), 64'd0);
    repeat (6) tick();
    trn_tbuf_av = 4'hF;

    // reset in the middle of a packet
    gc_host_addr = 64'h0000_0000_ABCD_0000;
    req_wait();
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      tick();
      if (!trn_tsrc_rdy_n && trn_tsof_n && trn_teof_n) found = 1;
    end
    chk(found, "reach_beat1", 64'(found), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk(trn_tsrc_rdy_n && !tx_busy && !tx_req, "rst_async",
        64'({trn_tsrc_rdy_n, tx_busy, tx_req}), 64'h4);
    tick(); tick();
    rst = 1'b0;
    repeat (3) tick();
    chk(trn_tsrc_rdy_n && trn_tsof_n, "no_resume", 64'({trn_tsrc_rdy_n, trn_tsof_n}), 64'h3);
    k0 = n_beats;
    gc_addr = 64'h0123_4567_89AB_CDEF;
    req_wait();
    repeat (10) tick();
    chk(n_beats - k0 == 3, "fresh_tlp", 64'(n_beats - k0), 64'd3);
    chk(exp_q.size() == 0, "fresh_queue_empty", 64'(exp_q.size()), 64'd0);

    // update held continuously
    a0 = n_ack;
    gc_updt = 1'b1;
    repeat (60) tick();
    gc_updt = 1'b0;
    repeat (10) tick();
    chk(n_ack - a0 >= 8, "held_acks", 64'(n_ack - a0), 64'd8);
    chk(exp_q.size() == 0 && !busy_m, "held_drained", 64'(exp_q.size()), 64'd0);

    // randomized run
    cfg_completer_id = 16'($urandom);
    wcnt = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      trn_tdst_rdy_n = ($urandom_range(0, 3) == 0);
      tx_gnt = ($urandom_range(0, 2) != 0);
      trn_tbuf_av = 4'($urandom);
      if ($urandom_range(0, 7) == 0) gc_host_addr = {$urandom, $urandom};
      if (gc_updt) begin
        if (gc_updt_ack) begin
          gc_updt = 1'b0; wcnt = 0;
        end else begin
          wcnt++;
          if (wcnt > 200) begin
            chk(wcnt <= 200, "rand_ack_timeout", 64'(wcnt), 64'd200);
            gc_updt = 1'b0; wcnt = 0;
          end
        end
      end else if ($urandom_range(0, 3) == 0) begin
        gc_addr = {$urandom, $urandom};
        gc_host_addr_vld = ($urandom_range(0, 3) != 0);
        gc_updt = 1'b1;
      end
    end
    trn_tdst_rdy_n = 1'b0; tx_gnt = 1'b1; trn_tbuf_av = 4'hF;
    for (int c = 0; c < 100 && gc_updt; c++) begin
      tick();
      if (gc_updt_ack) gc_updt = 1'b0;
    end
    gc_updt = 1'b0;
    repeat (12) tick();
    chk(exp_q.size() == 0 && !busy_m, "rand_drained", 64'(exp_q.size()), 64'd0);
    chk(drop_cnt == 32'(model_drop), "rand_drop_cnt", 64'(drop_cnt), 64'(model_drop));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
